// File: rtl/glitch_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// glitch_sweep_ctrl
//
// Sequences the glitch pulse engine across a 2-D sweep of trigger-to-glitch
// delay (inner loop) and glitch width (outer loop). Each (delay, width) point
// runs REPEAT attempts. One attempt does the following, in order:
//   1. Hold the target in reset for COOLDOWN cycles.
//   2. Wait for the trigger, bounded by TRIG_TIMEOUT cycles.
//   3. Arm the engine with the current delay and width.
//   4. Wait for the engine to report completion.
//   5. Sample the target success flag.
//
// Optional build macro:
//   STOP_ON_SUCCESS_EN - when defined, the first successful CHECK ends the
//                        sweep immediately. cur_delay and cur_width stay at
//                        the hit point.
//
// Ports:
//   clk          in   PLL clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   one-cycle pulse; starts a sweep from IDLE or FINISH
//   abort        in   level; returns to IDLE from any state
//   trigger      in   target trigger (already synchronised)
//   eng_arm      out  one-cycle arm pulse to the engine
//   eng_delay    out  [DW-1:0] delay for the armed attempt
//   eng_width    out  [WW-1:0] width for the armed attempt
//   eng_done     in   one-cycle completion pulse from the engine
//   success_in   in   target success flag, sampled in CHECK
//   target_reset out  holds the target in reset
//   busy         out  high in every state except IDLE and FINISH
//   sweep_done   out  high in FINISH
//   hit          out  sticky; set on the first success since start
//   hit_delay    out  [DW-1:0] delay of the first success
//   hit_width    out  [WW-1:0] width of the first success
//   miss_count   out  [15:0] trigger timeouts this sweep, saturating
// -----------------------------------------------------------------------------
module glitch_sweep_ctrl #(
  parameter int DW           = 32,
  parameter int WW           = 16,
  parameter int DELAY_START  = 0,
  parameter int DELAY_END    = 1000,
  parameter int DELAY_STEP   = 10,
  parameter int WIDTH_START  = 1,
  parameter int WIDTH_END    = 40,
  parameter int WIDTH_STEP   = 1,
  parameter int REPEAT       = 4,
  parameter int COOLDOWN     = 1024,
  parameter int TRIG_TIMEOUT = 12_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          trigger,
  output logic          eng_arm,
  output logic [DW-1:0] eng_delay,
  output logic [WW-1:0] eng_width,
  input  logic          eng_done,
  input  logic          success_in,
  output logic          target_reset,
  output logic          busy,
  output logic          sweep_done,
  output logic          hit,
  output logic [DW-1:0] hit_delay,
  output logic [WW-1:0] hit_width,
  output logic [15:0]   miss_count
);

  // One shared counter serves both the cooldown and the trigger timeout,
  // because those two phases never overlap.
  localparam int CMAX = (COOLDOWN > TRIG_TIMEOUT) ? COOLDOWN : TRIG_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int RW   = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  // Widen the sweep bounds by one bit so that cur + STEP cannot wrap
  // before it is compared against END.
  localparam logic [DW:0]   D_START_X = (DW+1)'(DELAY_START);
  localparam logic [DW:0]   D_END_X   = (DW+1)'(DELAY_END);
  localparam logic [DW:0]   D_STEP_X  = (DW+1)'(DELAY_STEP);
  localparam logic [WW:0]   W_START_X = (WW+1)'(WIDTH_START);
  localparam logic [WW:0]   W_END_X   = (WW+1)'(WIDTH_END);
  localparam logic [WW:0]   W_STEP_X  = (WW+1)'(WIDTH_STEP);
  localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TRIG_TIMEOUT - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RST_TGT   = 3'd1,
    WAIT_TRIG = 3'd2,
    FIRE      = 3'd3,
    WAIT_DONE = 3'd4,
    CHECK     = 3'd5,
    ADVANCE   = 3'd6,
    FINISH    = 3'd7
  } state_t;

  state_t state;
  state_t state_next;

  logic [DW-1:0] cur_delay;
  logic [WW-1:0] cur_width;
  logic [RW-1:0] rep;
  logic [CW-1:0] cnt;

  logic [DW:0] d_sum;
  logic [WW:0] w_sum;
  logic        delay_fits;
  logic        width_fits;
  logic        rep_last;
  logic        cool_end;
  logic        trig_tmo;

  assign d_sum      = {1'b0, cur_delay} + D_STEP_X;
  assign w_sum      = {1'b0, cur_width} + W_STEP_X;
  assign delay_fits = (d_sum <= D_END_X);
  assign width_fits = (w_sum <= W_END_X);
  assign rep_last   = (rep == REP_LAST);
  assign cool_end   = (cnt == COOL_LAST);
  assign trig_tmo   = (cnt == TMO_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE, FINISH: begin
        if (start) state_next = RST_TGT;
      end
      RST_TGT: begin
        if (cool_end) state_next = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        if (trigger)       state_next = FIRE;
        else if (trig_tmo) state_next = ADVANCE;
      end
      FIRE: begin
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (eng_done) state_next = CHECK;
      end
      CHECK: begin
`ifdef STOP_ON_SUCCESS_EN
        if (success_in) state_next = FINISH;
        else            state_next = ADVANCE;
`else
        state_next = ADVANCE;
`endif
      end
      ADVANCE: begin
        // The sweep ends only when all three counters roll over together.
        if (rep_last && !delay_fits && !width_fits) state_next = FINISH;
        else                                        state_next = RST_TGT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // abort overrides every other transition.
    if (abort) state_next = IDLE;
  end

  // The control outputs decode the state register directly. Because of that,
  // an async reset or an abort clears them as soon as the state leaves the
  // corresponding phase.
  assign eng_arm      = (state == FIRE);
  assign target_reset = (state == RST_TGT);
  assign busy         = (state != IDLE) && (state != FINISH);
  assign sweep_done   = (state == FINISH);

  // ---------------------------------------------------------------------------
  // Datapath: sweep position, counters, engine words, results
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_delay  <= D_START_X[DW-1:0];
      cur_width  <= W_START_X[WW-1:0];
      rep        <= '0;
      cnt        <= '0;
      eng_delay  <= '0;
      eng_width  <= '0;
      hit        <= 1'b0;
      hit_delay  <= '0;
      hit_width  <= '0;
      miss_count <= '0;
    end else if (!abort) begin
      // While abort is high everything is frozen. Results are retained, and
      // the next start reloads the sweep position.
      case (state)
        IDLE, FINISH: begin
          if (start) begin
            cur_delay  <= D_START_X[DW-1:0];
            cur_width  <= W_START_X[WW-1:0];
            rep        <= '0;
            cnt        <= '0;
            hit        <= 1'b0;
            hit_delay  <= '0;
            hit_width  <= '0;
            miss_count <= '0;
          end
        end
        RST_TGT: begin
          cnt <= cool_end ? '0 : cnt + 1'b1;
        end
        WAIT_TRIG: begin
          if (trigger) begin
            cnt       <= '0;
            // Latch on the way into FIRE, so the words are valid during the
            // arm pulse and stay stable until the next FIRE.
            eng_delay <= cur_delay;
            eng_width <= cur_width;
          end else if (trig_tmo) begin
            cnt <= '0;
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          if (success_in && !hit) begin
            hit       <= 1'b1;
            hit_delay <= cur_delay;
            hit_width <= cur_width;
          end
        end
        ADVANCE: begin
          cnt <= '0;
          if (!rep_last) begin
            rep <= rep + 1'b1;
          end else begin
            rep <= '0;
            if (delay_fits) begin
              cur_delay <= d_sum[DW-1:0];
            end else begin
              cur_delay <= D_START_X[DW-1:0];
              if (width_fits) cur_width <= w_sum[WW-1:0];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_glitch_sweep_ctrl
//
// Directed bench for glitch_sweep_ctrl. The main instance uses a small sweep:
//   delay 0..20 step 10, width 1..2 step 1, REPEAT=2, COOLDOWN=4,
//   TRIG_TIMEOUT=8.
// A second instance uses an 8-bit delay word with bounds near the top of the
// range, to check the no-wrap comparison.
// -----------------------------------------------------------------------------
module tb_glitch_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        trigger = 1'b0;
  logic        eng_arm;
  logic [31:0] eng_delay;
  logic [15:0] eng_width;
  logic        eng_done = 1'b0;
  logic        done_inj = 1'b0;
  logic        success_in = 1'b0;
  logic        target_reset;
  logic        busy;
  logic        sweep_done;
  logic        hit;
  logic [31:0] hit_delay;
  logic [15:0] hit_width;
  logic [15:0] miss_count;

  always #5 clk = ~clk;

  glitch_sweep_ctrl #(
    .DW(32), .WW(16),
    .DELAY_START(0), .DELAY_END(20), .DELAY_STEP(10),
    .WIDTH_START(1), .WIDTH_END(2), .WIDTH_STEP(1),
    .REPEAT(2), .COOLDOWN(4), .TRIG_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .trigger(trigger),
    .eng_arm(eng_arm), .eng_delay(eng_delay), .eng_width(eng_width),
    .eng_done(eng_done | done_inj), .success_in(success_in),
    .target_reset(target_reset), .busy(busy), .sweep_done(sweep_done),
    .hit(hit), .hit_delay(hit_delay), .hit_width(hit_width),
    .miss_count(miss_count)
  );

  // Wrap-bound instance
  logic        w_start = 1'b0;
  logic        w_abort = 1'b0;
  logic        w_trigger = 1'b1;
  logic        w_arm;
  logic [7:0]  w_delay;
  logic [15:0] w_width;
  logic        w_done = 1'b0;
  logic        w_success = 1'b0;
  logic        w_trst;
  logic        w_busy;
  logic        w_sweep_done;
  logic        w_hit;
  logic [7:0]  w_hit_delay;
  logic [15:0] w_hit_width;
  logic [15:0] w_miss;

  glitch_sweep_ctrl #(
    .DW(8), .WW(16),
    .DELAY_START(250), .DELAY_END(255), .DELAY_STEP(10),
    .WIDTH_START(1), .WIDTH_END(2), .WIDTH_STEP(1),
    .REPEAT(1), .COOLDOWN(4), .TRIG_TIMEOUT(8)
  ) dut_w (
    .clk(clk), .rst(rst), .start(w_start), .abort(w_abort), .trigger(w_trigger),
    .eng_arm(w_arm), .eng_delay(w_delay), .eng_width(w_width),
    .eng_done(w_done), .success_in(w_success),
    .target_reset(w_trst), .busy(w_busy), .sweep_done(w_sweep_done),
    .hit(w_hit), .hit_delay(w_hit_delay), .hit_width(w_hit_width),
    .miss_count(w_miss)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, got);
    end
  endtask

  // Engine model: returns eng_done 3 cycles after each arm.
  int done_cnt = 0;
  always @(negedge clk) begin
    eng_done = 1'b0;
    if (done_cnt != 0) begin
      done_cnt--;
      if (done_cnt == 0) eng_done = 1'b1;
    end
    if (eng_arm) done_cnt = 3;
  end

  int w_done_cnt = 0;
  always @(negedge clk) begin
    w_done = 1'b0;
    if (w_done_cnt != 0) begin
      w_done_cnt--;
      if (w_done_cnt == 0) w_done = 1'b1;
    end
    if (w_arm) w_done_cnt = 3;
  end

  // Arm logger (main instance)
  int          arm_cnt = 0;
  logic [31:0] arm_d [0:63];
  logic [15:0] arm_w [0:63];
  always @(negedge clk) begin
    if (eng_arm) begin
      if (arm_cnt < 64) begin
        arm_d[arm_cnt] = eng_delay;
        arm_w[arm_cnt] = eng_width;
      end
      arm_cnt++;
    end
  end

  // Arm logger (wrap instance)
  int          w_arm_cnt = 0;
  logic [7:0]  w_arm_d [0:7];
  logic [15:0] w_arm_w [0:7];
  always @(negedge clk) begin
    if (w_arm) begin
      if (w_arm_cnt < 8) begin
        w_arm_d[w_arm_cnt] = w_delay;
        w_arm_w[w_arm_cnt] = w_width;
      end
      w_arm_cnt++;
    end
  end

  // target_reset activity counters
  int   trst_cyc = 0;
  int   trst_rise = 0;
  logic trst_prev = 1'b0;
  always @(negedge clk) begin
    if (target_reset) trst_cyc++;
    if (target_reset && !trst_prev) trst_rise++;
    trst_prev = target_reset;
  end

  // Success source: success_in is high only on attempts 9 and 10, which are
  // the attempts at point (10,2).
  logic succ_en = 1'b0;
  always @(negedge clk) success_in = succ_en && (arm_cnt == 9 || arm_cnt == 10);

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_finish(input int bound, input string tag);
    int n = 0;
    while (!sweep_done && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!sweep_done) check(tag, 32'(sweep_done), 32'd1);
  endtask

  task automatic wait_arms(input int want, input int bound, input string tag);
    int n = 0;
    while (arm_cnt < want && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (arm_cnt < want) check(tag, 32'(arm_cnt), 32'(want));
  endtask

  int exp_d [0:11] = '{0, 0, 10, 10, 20, 20, 0, 0, 10, 10, 20, 20};
  int exp_w [0:11] = '{1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2};

  initial begin
    int n;
    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_sweep_done", 32'(sweep_done), 0);
    check("rst_eng_arm", 32'(eng_arm), 0);
    check("rst_target_reset", 32'(target_reset), 0);
    check("rst_hit", 32'(hit), 0);
    check("rst_miss", 32'(miss_count), 0);
    check("rst_eng_delay", eng_delay, 0);
    check("rst_eng_width", 32'(eng_width), 0);

    // ---------------- full sweep ----------------
    trigger = 1'b1;
    arm_cnt = 0;
    pulse_start();
    wait_arms(3, 200, "full_arm3_timeout");
    pulse_start();  // a start during a sweep must be ignored
    wait_finish(1000, "full_finish_timeout");
    check("full_arm_count", 32'(arm_cnt), 12);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("full_delay[%0d]", i), arm_d[i], 32'(exp_d[i]));
      check($sformatf("full_width[%0d]", i), 32'(arm_w[i]), 32'(exp_w[i]));
    end
    check("full_sweep_done", 32'(sweep_done), 1);
    check("full_busy", 32'(busy), 0);
    check("full_hit", 32'(hit), 0);
    check("full_miss", 32'(miss_count), 0);

    // ---------------- trigger timeout ----------------
    trigger = 1'b0;
    arm_cnt = 0;
    trst_cyc = 0;
    trst_rise = 0;
    pulse_start();
    check("tmo_busy_after_start", 32'(busy), 1);
    wait_finish(2000, "tmo_finish_timeout");
    check("tmo_arm_count", 32'(arm_cnt), 0);
    check("tmo_miss", 32'(miss_count), 12);
    check("tmo_trst_cycles", 32'(trst_cyc), 48);
    check("tmo_trst_pulses", 32'(trst_rise), 12);

    // ---------------- success capture ----------------
    trigger = 1'b1;
    arm_cnt = 0;
    succ_en = 1'b1;
    pulse_start();
    check("succ_miss_cleared", 32'(miss_count), 0);
    wait_finish(1000, "succ_finish_timeout");
    succ_en = 1'b0;
    check("succ_hit", 32'(hit), 1);
    check("succ_hit_delay", hit_delay, 10);
    check("succ_hit_width", 32'(hit_width), 2);
`ifdef STOP_ON_SUCCESS_EN
    check("succ_arm_count", 32'(arm_cnt), 9);
    check("succ_last_delay", eng_delay, 10);
`else
    check("succ_arm_count", 32'(arm_cnt), 12);
    check("succ_last_delay", eng_delay, 20);
`endif
    check("succ_last_width", 32'(eng_width), 2);

    // ---------------- abort ----------------
    // The first attempt times out (miss=1). After that the trigger is held
    // high, so the 4th arm is attempt 5, at point (20,1).
    trigger = 1'b0;
    arm_cnt = 0;
    pulse_start();
    check("abort_hit_cleared", 32'(hit), 0);
    n = 0;
    while (miss_count != 16'd1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_first_miss", 32'(miss_count), 1);
    trigger = 1'b1;
    wait_arms(4, 300, "abort_arm4_timeout");
    check("abort_arm4_delay", arm_d[3], 20);
    @(negedge clk);          // now in WAIT_DONE of attempt 5
    abort = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_sweep_done", 32'(sweep_done), 0);
    check("abort_eng_arm", 32'(eng_arm), 0);
    check("abort_target_reset", 32'(target_reset), 0);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    done_inj = 1'b1;         // stray completion pulse while IDLE
    @(negedge clk);
    done_inj = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_still_idle", 32'(busy), 0);
    check("abort_no_new_arm", 32'(arm_cnt), 4);
    check("abort_miss_retained", 32'(miss_count), 1);
    arm_cnt = 0;
    pulse_start();
    check("restart_miss_cleared", 32'(miss_count), 0);
    check("restart_busy", 32'(busy), 1);
    wait_arms(1, 100, "restart_arm_timeout");
    check("restart_delay", arm_d[0], 0);
    check("restart_width", 32'(arm_w[0]), 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    // ---------------- async reset mid RST_TGT ----------------
    pulse_start();
    n = 0;
    while (!target_reset && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("arst_in_rst_tgt", 32'(target_reset), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_target_reset", 32'(target_reset), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_eng_delay", eng_delay, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_stays_idle", 32'(busy), 0);
    check("arst_sweep_done", 32'(sweep_done), 0);

    // ---------------- wrap bound (8-bit delay) ----------------
    @(negedge clk); w_start = 1'b1;
    @(negedge clk); w_start = 1'b0;
    n = 0;
    while (!w_sweep_done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("wrap_sweep_done", 32'(w_sweep_done), 1);
    check("wrap_arm_count", 32'(w_arm_cnt), 2);
    check("wrap_delay0", 32'(w_arm_d[0]), 250);
    check("wrap_width0", 32'(w_arm_w[0]), 1);
    check("wrap_delay1", 32'(w_arm_d[1]), 250);
    check("wrap_width1", 32'(w_arm_w[1]), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
